// File: rtl/spi_burst_stash.sv
// Byte-burst sequencer upstream of an SPI master: TX/RX byte stashes, one frame in flight at a time,
// chip select held across the whole burst.
module spi_burst_stash #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int PTR_W       = 4,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              CTRL_CLK,
  input  logic              RST,
  input  logic              HOST_WR_EN,
  input  logic [DATA_W-1:0] HOST_WR_DATA,
  output logic              TX_FULL,
  output logic [PTR_W:0]    TX_LEVEL,
  input  logic              GO,
  input  logic              HOST_RD_EN,
  output logic [DATA_W-1:0] HOST_RD_DATA,
  output logic              RX_EMPTY,
  output logic [PTR_W:0]    RX_LEVEL,
  output logic              BUSY,
  output logic              BURST_DONE,
  output logic              ERR_TIMEOUT,
  output logic              RX_OVF,
  input  logic              CLR_ERR,
  output logic              XFER_START,
  output logic [DATA_W-1:0] MOSI_data,
  input  logic              XFER_DONE,
  input  logic [DATA_W-1:0] MISO_data,
  output logic              CS_HOLD
);

  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_GAP, S_FINISH} state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [PTR_W-1:0]  tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [PTR_W:0]    tx_level, rx_level, remaining, tx_flush;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              go_ok, tx_push, tx_pop, done_seen, timeout_hit;
  logic              rx_full, rx_pop, rx_push, rx_drop;

  assign TX_LEVEL = tx_level;
  assign RX_LEVEL = rx_level;
  assign TX_FULL  = (tx_level == FULL_LVL);
  assign RX_EMPTY = (rx_level == '0);
  assign rx_full  = (rx_level == FULL_LVL);
  assign HOST_RD_DATA = RX_EMPTY ? '0 : rx_mem[rx_rd_ptr];

  assign go_ok       = (state == S_IDLE) && GO && (tx_level != '0);
  assign tx_push     = HOST_WR_EN && !TX_FULL;
  assign tx_pop      = (state == S_LOAD);
  assign done_seen   = (state == S_WAIT) && XFER_DONE;
  assign timeout_hit = (state == S_WAIT) && !XFER_DONE && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  // On timeout the in-flight byte is already gone; only the not-yet-loaded rest of the burst is flushed.
  assign tx_flush    = timeout_hit ? (remaining - (PTR_W+1)'(1)) : '0;
  assign rx_pop      = HOST_RD_EN && !RX_EMPTY;
  assign rx_push     = done_seen && (!rx_full || rx_pop);
  assign rx_drop     = done_seen && rx_full && !rx_pop;

  always_ff @(posedge CTRL_CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (go_ok) next_state = S_LOAD;
      S_LOAD:   next_state = S_ISSUE;
      S_ISSUE:  next_state = S_WAIT;
      S_WAIT: begin
        if (XFER_DONE)        next_state = (remaining == (PTR_W+1)'(1)) ? S_FINISH : S_GAP;
        else if (timeout_hit) next_state = S_FINISH;
      end
      S_GAP:    if (gap_cnt == GAP_W'(GAP_CYC - 1)) next_state = S_LOAD;
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY       = 1'b0;
    CS_HOLD    = 1'b0;
    XFER_START = 1'b0;
    BURST_DONE = 1'b0;
    case (state)
      S_LOAD, S_WAIT, S_GAP: begin BUSY = 1'b1; CS_HOLD = 1'b1; end
      S_ISSUE:  begin BUSY = 1'b1; CS_HOLD = 1'b1; XFER_START = 1'b1; end
      S_FINISH: begin BUSY = 1'b1; BURST_DONE = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge CTRL_CLK) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= HOST_WR_DATA;
    if (rx_push) rx_mem[rx_wr_ptr] <= MISO_data;
  end

  always_ff @(posedge CTRL_CLK) begin
    if (RST) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_level    <= '0;
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_level    <= '0;
      remaining   <= '0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
      MOSI_data   <= '0;
      ERR_TIMEOUT <= 1'b0;
      RX_OVF      <= 1'b0;
    end else begin
      tx_wr_ptr <= tx_wr_ptr + PTR_W'(tx_push);
      tx_rd_ptr <= tx_rd_ptr + PTR_W'(tx_pop) + tx_flush[PTR_W-1:0];
      tx_level  <= tx_level + (PTR_W+1)'(tx_push) - (PTR_W+1)'(tx_pop) - tx_flush;
      rx_wr_ptr <= rx_wr_ptr + PTR_W'(rx_push);
      rx_rd_ptr <= rx_rd_ptr + PTR_W'(rx_pop);
      rx_level  <= rx_level + (PTR_W+1)'(rx_push) - (PTR_W+1)'(rx_pop);

      if (go_ok)          remaining <= tx_level;
      else if (done_seen) remaining <= remaining - (PTR_W+1)'(1);

      if (tx_pop) MOSI_data <= tx_mem[tx_rd_ptr];

      gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;

      if (state == S_ISSUE)     to_cnt <= '0;
      else if (state == S_WAIT) to_cnt <= to_cnt + TO_W'(1);

      if (timeout_hit)  ERR_TIMEOUT <= 1'b1;
      else if (CLR_ERR) ERR_TIMEOUT <= 1'b0;

      if (rx_drop)      RX_OVF <= 1'b1;
      else if (CLR_ERR) RX_OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_burst_stash.sv
// Directed bench for spi_burst_stash; the master side is modelled by serve_frame (echoes ~MOSI).
module tb_spi_burst_stash;

  localparam int TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       rst, wr_en, go, rd_en, clr_err, xfer_done;
  logic [7:0] wr_data, miso;
  logic       tx_full, rx_empty, busy, burst_done, err_timeout, rx_ovf, xfer_start, cs_hold;
  logic [4:0] tx_level, rx_level;
  logic [7:0] rd_data, mosi;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int bdone_cnt = 0;
  int cs_gap = 0;

  always #5 clk = ~clk;

  spi_burst_stash dut (
    .CTRL_CLK(clk), .RST(rst),
    .HOST_WR_EN(wr_en), .HOST_WR_DATA(wr_data), .TX_FULL(tx_full), .TX_LEVEL(tx_level),
    .GO(go), .HOST_RD_EN(rd_en), .HOST_RD_DATA(rd_data), .RX_EMPTY(rx_empty), .RX_LEVEL(rx_level),
    .BUSY(busy), .BURST_DONE(burst_done), .ERR_TIMEOUT(err_timeout), .RX_OVF(rx_ovf),
    .CLR_ERR(clr_err), .XFER_START(xfer_start), .MOSI_data(mosi), .XFER_DONE(xfer_done),
    .MISO_data(miso), .CS_HOLD(cs_hold)
  );

  always @(negedge clk) begin
    if (xfer_start === 1'b1) start_cnt++;
    if (burst_done === 1'b1) bdone_cnt++;
    if (busy === 1'b1 && cs_hold !== 1'b1 && burst_done !== 1'b1) cs_gap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic pop_byte();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  // Waits (bounded) for XFER_START, then answers two WAIT cycles later with ~MOSI; waited=-1 on no start.
  task automatic serve_frame(input logic rd_in_done, output logic [7:0] mosi_seen, output int waited);
    waited = 0;
    mosi_seen = 8'h00;
    while (xfer_start !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (xfer_start === 1'b1) begin
      mosi_seen = mosi;
      tick();
      tick();
      miso = ~mosi; xfer_done = 1'b1; rd_en = rd_in_done;
      tick();
      xfer_done = 1'b0; rd_en = 1'b0;
    end else begin
      waited = -1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({busy, cs_hold, xfer_start, burst_done, tx_full, err_timeout, rx_ovf, rx_empty} !== 8'b0000_0001) begin
      bad++;
      $display("[TB] FAIL reset_flags: got=%b exp=00000001",
               {busy, cs_hold, xfer_start, burst_done, tx_full, err_timeout, rx_ovf, rx_empty});
    end
    total++;
    if ({tx_level, rx_level, mosi, rd_data} !== 26'd0) begin
      bad++;
      $display("[TB] FAIL reset_data: tx_lvl=%0d rx_lvl=%0d mosi=%h rd=%h exp all 0", tx_level, rx_level, mosi, rd_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] m;
    int w, s0, b0;
    s0 = start_cnt; b0 = bdone_cnt; cs_gap = 0;
    push_byte(8'hA5);
    push_byte(8'h3C);
    pulse_go();
    total++;
    if (busy !== 1'b1 || cs_hold !== 1'b1) begin
      bad++; $display("[TB] FAIL basic_load: busy=%b cs_hold=%b exp 1 1", busy, cs_hold);
    end
    serve_frame(1'b0, m, w);
    total++;
    if (w !== 1 || m !== 8'hA5) begin
      bad++; $display("[TB] FAIL basic_f0: wait=%0d mosi=%h exp 1 a5", w, m);
    end
    serve_frame(1'b0, m, w);
    total++;
    if (w !== 5 || m !== 8'h3C) begin
      bad++; $display("[TB] FAIL basic_f1: wait=%0d mosi=%h exp 5 3c", w, m);
    end
    total++;
    if (burst_done !== 1'b1 || cs_hold !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL basic_finish: done=%b cs=%b busy=%b exp 1 0 1", burst_done, cs_hold, busy);
    end
    tick();
    total++;
    if (busy !== 1'b0 || tx_level !== 5'd0 || rx_level !== 5'd2) begin
      bad++; $display("[TB] FAIL basic_idle: busy=%b tx=%0d rx=%0d exp 0 0 2", busy, tx_level, rx_level);
    end
    total++;
    if (rd_data !== 8'h5A) begin
      bad++; $display("[TB] FAIL basic_rx0: got=%h exp=5a", rd_data);
    end
    pop_byte();
    total++;
    if (rd_data !== 8'hC3) begin
      bad++; $display("[TB] FAIL basic_rx1: got=%h exp=c3", rd_data);
    end
    pop_byte();
    total++;
    if (rx_empty !== 1'b1) begin
      bad++; $display("[TB] FAIL basic_rx_empty: got=%b exp=1", rx_empty);
    end
    total++;
    if (start_cnt - s0 !== 2 || bdone_cnt - b0 !== 1 || cs_gap !== 0) begin
      bad++;
      $display("[TB] FAIL basic_counts: starts=%0d dones=%0d cs_gaps=%0d exp 2 1 0", start_cnt - s0, bdone_cnt - b0, cs_gap);
    end
  endtask

  task automatic test_full_wrap();
    logic [7:0] m, d;
    int w, s0;
    s0 = start_cnt; cs_gap = 0;
    for (int i = 0; i < 16; i++) begin
      d = 8'h10 + 8'(i);
      push_byte(d);
    end
    total++;
    if (tx_full !== 1'b1 || tx_level !== 5'd16) begin
      bad++; $display("[TB] FAIL full_flag: full=%b lvl=%0d exp 1 16", tx_full, tx_level);
    end
    push_byte(8'hFF);
    total++;
    if (tx_level !== 5'd16) begin
      bad++; $display("[TB] FAIL full_drop: lvl=%0d exp=16", tx_level);
    end
    pulse_go();
    for (int i = 0; i < 16; i++) begin
      d = 8'h10 + 8'(i);
      serve_frame(1'b0, m, w);
      total++;
      if (m !== d || w < 0) begin
        bad++; $display("[TB] FAIL full_frame%0d: mosi=%h wait=%0d exp mosi=%h", i, m, w, d);
      end
    end
    tick();
    total++;
    if (start_cnt - s0 !== 16 || tx_level !== 5'd0 || rx_level !== 5'd16 || busy !== 1'b0 || cs_gap !== 0) begin
      bad++;
      $display("[TB] FAIL full_end: starts=%0d tx=%0d rx=%0d busy=%b cs_gaps=%0d exp 16 0 16 0 0",
               start_cnt - s0, tx_level, rx_level, busy, cs_gap);
    end
    total++;
    if (rd_data !== 8'hEF) begin
      bad++; $display("[TB] FAIL full_rx_head: got=%h exp=ef", rd_data);
    end
  endtask

  task automatic test_rx_overflow();
    logic [7:0] m, e;
    int w;
    push_byte(8'h77);
    pulse_go();
    serve_frame(1'b0, m, w);
    total++;
    if (rx_ovf !== 1'b1 || rx_level !== 5'd16 || m !== 8'h77) begin
      bad++; $display("[TB] FAIL ovf_set: ovf=%b rx=%0d mosi=%h exp 1 16 77", rx_ovf, rx_level, m);
    end
    tick();
    total++;
    if (rd_data !== 8'hEF) begin
      bad++; $display("[TB] FAIL ovf_head_kept: got=%h exp=ef", rd_data);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++;
    if (rx_ovf !== 1'b0) begin
      bad++; $display("[TB] FAIL ovf_clear: got=%b exp=0", rx_ovf);
    end
    push_byte(8'h66);
    pulse_go();
    serve_frame(1'b1, m, w);
    total++;
    if (rx_ovf !== 1'b0 || rx_level !== 5'd16) begin
      bad++; $display("[TB] FAIL ovf_pop_same_cycle: ovf=%b rx=%0d exp 0 16", rx_ovf, rx_level);
    end
    tick();
    for (int i = 0; i < 16; i++) begin
      e = (i < 15) ? ~(8'h11 + 8'(i)) : 8'h99;
      total++;
      if (rd_data !== e) begin
        bad++; $display("[TB] FAIL ovf_drain%0d: got=%h exp=%h", i, rd_data, e);
      end
      pop_byte();
    end
    total++;
    if (rx_empty !== 1'b1) begin
      bad++; $display("[TB] FAIL ovf_drain_empty: got=%b exp=1", rx_empty);
    end
  endtask

  task automatic test_timeout();
    int n, s0;
    s0 = start_cnt;
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    pulse_go();
    n = 0;
    while (xfer_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (xfer_start !== 1'b1) begin
      bad++; $display("[TB] FAIL to_start: xfer_start=%b exp=1", xfer_start);
    end
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    total++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL to_early: err=%b busy=%b exp 0 1", err_timeout, busy);
    end
    tick();
    tick();
    total++;
    if (err_timeout !== 1'b1 || burst_done !== 1'b1 || cs_hold !== 1'b0 || tx_level !== 5'd0) begin
      bad++;
      $display("[TB] FAIL to_abort: err=%b done=%b cs=%b tx=%0d exp 1 1 0 0", err_timeout, burst_done, cs_hold, tx_level);
    end
    tick();
    total++;
    if (busy !== 1'b0 || start_cnt - s0 !== 1) begin
      bad++; $display("[TB] FAIL to_idle: busy=%b starts=%0d exp 0 1", busy, start_cnt - s0);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++;
    if (err_timeout !== 1'b0) begin
      bad++; $display("[TB] FAIL to_clear: got=%b exp=0", err_timeout);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] m;
    int w, s0, b0;
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
    pulse_go();
    serve_frame(1'b0, m, w);
    total++;
    if (busy !== 1'b1 || cs_hold !== 1'b1 || rx_level !== 5'd1 || tx_level !== 5'd3) begin
      bad++; $display("[TB] FAIL rst_pre: busy=%b cs=%b rx=%0d tx=%0d exp 1 1 1 3", busy, cs_hold, rx_level, tx_level);
    end
    s0 = start_cnt; b0 = bdone_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || cs_hold !== 1'b0 || tx_level !== 5'd0 || rx_level !== 5'd0 ||
        xfer_start !== 1'b0 || burst_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_mid: busy=%b cs=%b tx=%0d rx=%0d start=%b done=%b exp all 0",
               busy, cs_hold, tx_level, rx_level, xfer_start, burst_done);
    end
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (start_cnt !== s0 || bdone_cnt !== b0) begin
      bad++; $display("[TB] FAIL rst_quiet: starts=%0d dones=%0d exp 0 0", start_cnt - s0, bdone_cnt - b0);
    end
  endtask

  task automatic test_go_ignored();
    logic [7:0] m;
    int w, s0, b0;
    s0 = start_cnt; b0 = bdone_cnt;
    push_byte(8'h11);
    push_byte(8'h22);
    pulse_go();
    serve_frame(1'b0, m, w);
    total++;
    if (w !== 1 || m !== 8'h11) begin
      bad++; $display("[TB] FAIL go_busy_f0: wait=%0d mosi=%h exp 1 11", w, m);
    end
    push_byte(8'h33);
    pulse_go();
    serve_frame(1'b0, m, w);
    total++;
    if (w !== 3 || m !== 8'h22) begin
      bad++; $display("[TB] FAIL go_busy_f1: wait=%0d mosi=%h exp 3 22", w, m);
    end
    for (int i = 0; i < 12; i++) tick();
    total++;
    if (start_cnt - s0 !== 2 || bdone_cnt - b0 !== 1 || tx_level !== 5'd1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL go_busy_end: starts=%0d dones=%0d tx=%0d busy=%b exp 2 1 1 0",
               start_cnt - s0, bdone_cnt - b0, tx_level, busy);
    end
    pulse_go();
    serve_frame(1'b0, m, w);
    total++;
    if (m !== 8'h33 || w !== 1) begin
      bad++; $display("[TB] FAIL go_held_byte: mosi=%h wait=%0d exp 33 1", m, w);
    end
    tick();
    s0 = start_cnt;
    pulse_go();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("[TB] FAIL go_empty_busy: got=%b exp=0", busy);
    end
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (start_cnt !== s0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL go_empty_quiet: starts=%0d busy=%b exp 0 0", start_cnt - s0, busy);
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; go = 1'b0; rd_en = 1'b0;
    clr_err = 1'b0; xfer_done = 1'b0; miso = 8'h00;
    test_reset();
    test_basic();
    test_full_wrap();
    test_rx_overflow();
    test_timeout();
    test_reset_mid_burst();
    test_go_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
